rv_muldiv_unit: RTL

RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

---
 rtl/rv_muldiv_pkg.sv | 39 +++
 rtl/rv_muldiv_fixup.sv | 40 ++++
 rtl/rv_muldiv_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit and the instruction decoder.
package rv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
           (op == F3_DIV) || (op == F3_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  // Absolute value when the operand is interpreted as signed and negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv_muldiv_fixup.sv
// Final-cycle result selection: sign correction, divide-by-zero and overflow cases.
module rv_muldiv_fixup
  import rv_muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] acc_i,
  output logic [31:0] r_o
);

  logic        sa;
  logic        sb;
  logic        div_zero;
  logic        ovf;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  // Restore signs on the magnitude results and pick the architectural result.
  always_comb begin
    sa       = op_a_signed(op_i) & a_i[31];
    sb       = op_b_signed(op_i) & b_i[31];
    div_zero = (b_i == 32'd0);
    ovf      = op_b_signed(op_i) && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    prod     = (sa ^ sb) ? (~acc_i + 64'd1) : acc_i;
    quo      = (sa ^ sb) ? (~acc_i[31:0] + 32'd1) : acc_i[31:0];
    rem      = sa ? (~acc_i[63:32] + 32'd1) : acc_i[63:32];
    r_o      = '0;
    unique case (op_i)
      F3_MUL:                        r_o = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  r_o = prod[63:32];
      F3_DIV, F3_DIVU:               r_o = div_zero ? 32'hFFFF_FFFF :
                                           (ovf ? 32'h8000_0000 : quo);
      F3_REM, F3_REMU:               r_o = div_zero ? a_i : (ovf ? 32'd0 : rem);
      default:                       r_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps plus one fix-up cycle, fixed latency.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        acc_q;
  logic [31:0]        opnd_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [2:0]         op_q;
  logic [31:0]        r_q;
  logic               done_q;

  logic               accept;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [32:0]        mul_sum;
  logic [32:0]        div_top;
  logic [31:0]        div_diff;
  logic [63:0]        acc_step;
  logic [31:0]        fix_r;

  // Next-state logic; flush squashes everything and beats a simultaneous start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = funct3[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mag_a    = mag32(a, op_a_signed(funct3));
    mag_b    = mag32(b, op_b_signed(funct3));
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_top  = acc_q[63:31];
    div_diff = div_top[31:0] - opnd_q;
    acc_step = {mul_sum, acc_q[31:1]};
    if (state_q == ST_DIV) begin
      if (div_top >= {1'b0, opnd_q}) acc_step = {div_diff, acc_q[30:0], 1'b1};
      else                           acc_step = {div_top[31:0], acc_q[30:0], 1'b0};
    end
  end

  rv_muldiv_fixup u_fixup (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_i (acc_q),
    .r_o   (fix_r)
  );

  // State, operand capture, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FIX) && !flush;
      if (accept) begin
        op_q  <= funct3;
        a_q   <= a;
        b_q   <= b;
        cnt_q <= '0;
        if (funct3[2]) begin
          acc_q  <= {32'd0, mag_a};
          opnd_q <= mag_b;
        end else begin
          acc_q  <= {32'd0, mag_b};
          opnd_q <= mag_a;
        end
      end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_FIX) && !flush) r_q <= fix_r;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign r    = r_q;

endmodule
